// File: rtl/nasti_memtest_master_if.sv
// NASTI channel bundle (AXI4-style AW/W/B/AR/R) with master and slave views.
//
// Handshake rule for every channel: a transfer happens on the rising clock
// edge where valid && ready are both high. Once valid is raised, the source
// keeps valid high and the payload unchanged until that edge. The source never
// waits for ready before raising valid.
interface nasti_channel #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int USER_WIDTH = 1
);
  // write address
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;
  // write data
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;
  // write response
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;
  // read address
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;
  // read data
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/nasti_memtest_master.sv
// Memory test master: writes an address-derived pattern over a region in
// INCR bursts, reads it back and counts data/response/last errors.
// One transaction is outstanding at a time; all outputs are registered.
module nasti_memtest_master #(
  parameter int                    ID_WIDTH   = 1,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 128,
  parameter int                    USER_WIDTH = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    BURST_LEN  = 4,
  parameter int                    NUM_BURSTS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [2:0]            dbg_state,
  nasti_channel.master          nasti
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int LANES = DATA_WIDTH / 32;
  localparam int CNT_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

  localparam logic [ADDR_WIDTH-1:0] BEAT_INC   = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] BURST_INC  = ADDR_WIDTH'(BURST_LEN * BYTES);
  localparam logic [8:0]            LAST_BEAT  = 9'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]      LAST_BURST = CNT_W'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t state, state_d;

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  start_acc, last_burst;
  logic                  exp_last, b_bad, r_bad, err_event;
  logic [ADDR_WIDTH-1:0] err_addr;
  logic [15:0]           err_count_d;
  logic [CNT_W-1:0]      burst_cnt;
  logic [ADDR_WIDTH-1:0] burst_addr;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [8:0]            beat;

  // Lane k of the beat at byte address a holds (a + 4k) mod 2^32.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] a32;
    logic [DATA_WIDTH-1:0] p;
    a32 = 32'(a);
    p   = '0;
    for (int k = 0; k < LANES; k++) begin
      p[32*k +: 32] = a32 + 32'(4 * k);
    end
    return p;
  endfunction

  assign aw_hs      = nasti.aw_valid && nasti.aw_ready;
  assign w_hs       = nasti.w_valid  && nasti.w_ready;
  assign b_hs       = nasti.b_valid  && nasti.b_ready;
  assign ar_hs      = nasti.ar_valid && nasti.ar_ready;
  assign r_hs       = nasti.r_valid  && nasti.r_ready;
  assign start_acc  = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_burst = (burst_cnt == LAST_BURST);
  assign dbg_state  = state;

  // Constant NASTI fields; the response user bits are not interpreted.
  assign nasti.aw_id     = '0;
  assign nasti.aw_lock   = 1'b0;
  assign nasti.aw_cache  = '0;
  assign nasti.aw_prot   = '0;
  assign nasti.aw_qos    = '0;
  assign nasti.aw_region = '0;
  assign nasti.aw_user   = '0;
  assign nasti.w_user    = '0;
  assign nasti.ar_id     = '0;
  assign nasti.ar_lock   = 1'b0;
  assign nasti.ar_cache  = '0;
  assign nasti.ar_prot   = '0;
  assign nasti.ar_qos    = '0;
  assign nasti.ar_region = '0;
  assign nasti.ar_user   = '0;

  logic unused_user;
  assign unused_user = ^{nasti.b_user, nasti.r_user};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next state: each phase advances on its final handshake.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_d = S_AW;
      S_AW:           if (aw_hs) state_d = S_W;
      S_W:            if (w_hs && nasti.w_last) state_d = S_B;
      S_B:            if (b_hs) state_d = last_burst ? S_AR : S_AW;
      S_AR:           if (ar_hs) state_d = S_R;
      S_R:            if (r_hs && nasti.r_last) state_d = last_burst ? S_DONE : S_AR;
      default:        state_d = S_IDLE;
    endcase
  end

  // Error detection for the current B or R handshake and the saturating count.
  always_comb begin
    exp_last  = (beat == LAST_BEAT);
    b_bad     = (nasti.b_resp != 2'b00) || (nasti.b_id != '0);
    r_bad     = (nasti.r_resp != 2'b00) || (nasti.r_id != '0) ||
                (nasti.r_data != pattern(beat_addr)) ||
                (nasti.r_last != exp_last) || (beat > LAST_BEAT);
    err_event = (b_hs && b_bad) || (r_hs && r_bad);
    err_addr  = b_hs ? burst_addr : beat_addr;
    err_count_d = err_count;
    if (start_acc)
      err_count_d = '0;
    else if (err_event && (err_count != 16'hFFFF))
      err_count_d = err_count + 16'd1;
  end

  // Write address channel: raise one cycle into AW, drop after the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      nasti.aw_valid <= 1'b0;
      nasti.aw_addr  <= '0;
      nasti.aw_len   <= '0;
      nasti.aw_size  <= '0;
      nasti.aw_burst <= '0;
    end else if ((state == S_AW) && !nasti.aw_valid) begin
      nasti.aw_valid <= 1'b1;
      nasti.aw_addr  <= burst_addr;
      nasti.aw_len   <= 8'(BURST_LEN - 1);
      nasti.aw_size  <= 3'(SIZE);
      nasti.aw_burst <= 2'b01;
    end else if (aw_hs) begin
      nasti.aw_valid <= 1'b0;
    end
  end

  // Read address channel: same shape as the write address channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      nasti.ar_valid <= 1'b0;
      nasti.ar_addr  <= '0;
      nasti.ar_len   <= '0;
      nasti.ar_size  <= '0;
      nasti.ar_burst <= '0;
    end else if ((state == S_AR) && !nasti.ar_valid) begin
      nasti.ar_valid <= 1'b1;
      nasti.ar_addr  <= burst_addr;
      nasti.ar_len   <= 8'(BURST_LEN - 1);
      nasti.ar_size  <= 3'(SIZE);
      nasti.ar_burst <= 2'b01;
    end else if (ar_hs) begin
      nasti.ar_valid <= 1'b0;
    end
  end

  // Write data: first beat loads on the AW handshake, later beats on each W handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      nasti.w_valid <= 1'b0;
      nasti.w_data  <= '0;
      nasti.w_strb  <= '0;
      nasti.w_last  <= 1'b0;
    end else if (aw_hs) begin
      nasti.w_valid <= 1'b1;
      nasti.w_data  <= pattern(burst_addr);
      nasti.w_strb  <= '1;
      nasti.w_last  <= (BURST_LEN == 1);
    end else if (w_hs) begin
      if (nasti.w_last) begin
        nasti.w_valid <= 1'b0;
        nasti.w_last  <= 1'b0;
      end else begin
        nasti.w_data  <= pattern(beat_addr + BEAT_INC);
        nasti.w_last  <= ((beat + 9'd1) == LAST_BEAT);
      end
    end
  end

  // Response readies are high for exactly the cycles spent in B and R.
  always_ff @(posedge clk) begin
    if (rst) begin
      nasti.b_ready <= 1'b0;
      nasti.r_ready <= 1'b0;
    end else begin
      nasti.b_ready <= (state_d == S_B);
      nasti.r_ready <= (state_d == S_R);
    end
  end

  // Burst and beat position; the burst counter wraps to BASE_ADDR on entry to AR.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt  <= '0;
      burst_addr <= '0;
      beat       <= '0;
      beat_addr  <= '0;
    end else begin
      if (start_acc) begin
        burst_cnt  <= '0;
        burst_addr <= BASE_ADDR;
      end else if (b_hs) begin
        if (last_burst) begin
          burst_cnt  <= '0;
          burst_addr <= BASE_ADDR;
        end else begin
          burst_cnt  <= burst_cnt + CNT_W'(1);
          burst_addr <= burst_addr + BURST_INC;
        end
      end else if (r_hs && nasti.r_last && !last_burst) begin
        burst_cnt  <= burst_cnt + CNT_W'(1);
        burst_addr <= burst_addr + BURST_INC;
      end
      // beat saturates one past the last beat so overrun beats stay flagged
      if (aw_hs || ar_hs) begin
        beat      <= '0;
        beat_addr <= burst_addr;
      end else if (w_hs || r_hs) begin
        if (beat <= LAST_BEAT) beat <= beat + 9'd1;
        beat_addr <= beat_addr + BEAT_INC;
      end
    end
  end

  // Status outputs; pass uses the count including any error on the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count      <= '0;
      first_err_addr <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      err_count <= err_count_d;
      if (start_acc)
        first_err_addr <= '0;
      else if (err_event && (err_count == 16'd0))
        first_err_addr <= err_addr;
      busy <= (state_d != S_IDLE) && (state_d != S_DONE);
      done <= (state_d == S_DONE);
      pass <= (state_d == S_DONE) && (err_count_d == 16'd0);
    end
  end

endmodule

// File: tb/tb_nasti_memtest_master.sv
// Testbench for nasti_memtest_master: behavioural slave with fault modes,
// scoreboard on AW/W/AR handshakes, directed scenario runs and a summary.
module tb_nasti_memtest_master;

  localparam int IDW = 1;
  localparam int AWD = 16;
  localparam int DW  = 128;
  localparam int UW  = 1;
  localparam int BL  = 4;
  localparam int NB  = 2;
  localparam logic [15:0] BASE = 16'h1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [15:0] first_err_addr;
  logic [2:0]  dbg_state;

  nasti_channel #(.ID_WIDTH(IDW), .ADDR_WIDTH(AWD), .DATA_WIDTH(DW), .USER_WIDTH(UW)) nasti ();

  nasti_memtest_master #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AWD), .DATA_WIDTH(DW), .USER_WIDTH(UW),
    .BASE_ADDR(BASE), .BURST_LEN(BL), .NUM_BURSTS(NB)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .dbg_state(dbg_state),
    .nasti(nasti)
  );

  // ---------------- scoreboard state ----------------
  logic [46:0]  exp_aw_q[$];
  logic [145:0] exp_w_q[$];
  logic [46:0]  exp_ar_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int w_cnt    = 0;
  int mode     = 0;  // 0 clean, 1 backpressure, 2 corrupt, 3 b_resp error, 4 early r_last

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  function automatic logic [46:0] addr_exp(input logic [15:0] a);
    return {18'b0, 8'd3, 3'd4, 2'b01, a};
  endfunction

  function automatic logic [145:0] w_exp(input logic [127:0] d, input logic last);
    return {1'b0, 16'hFFFF, last, d};
  endfunction

  task automatic flush_q();
    exp_aw_q.delete();
    exp_w_q.delete();
    exp_ar_q.delete();
  endtask

  // Hand-computed traffic for BASE=0x1000, 4 beats x 16 bytes, 2 bursts.
  task automatic push_expected();
    exp_aw_q.push_back(addr_exp(16'h1000));
    exp_aw_q.push_back(addr_exp(16'h1040));
    exp_w_q.push_back(w_exp(128'h0000100C_00001008_00001004_00001000, 1'b0));
    exp_w_q.push_back(w_exp(128'h0000101C_00001018_00001014_00001010, 1'b0));
    exp_w_q.push_back(w_exp(128'h0000102C_00001028_00001024_00001020, 1'b0));
    exp_w_q.push_back(w_exp(128'h0000103C_00001038_00001034_00001030, 1'b1));
    exp_w_q.push_back(w_exp(128'h0000104C_00001048_00001044_00001040, 1'b0));
    exp_w_q.push_back(w_exp(128'h0000105C_00001058_00001054_00001050, 1'b0));
    exp_w_q.push_back(w_exp(128'h0000106C_00001068_00001064_00001060, 1'b0));
    exp_w_q.push_back(w_exp(128'h0000107C_00001078_00001074_00001070, 1'b1));
    exp_ar_q.push_back(addr_exp(16'h1000));
    exp_ar_q.push_back(addr_exp(16'h1040));
  endtask

  // ---------------- behavioural slave (drives at negedge) ----------------
  logic [127:0] mem [logic [15:0]];
  logic         b_pend;
  int           b_burst, aw_cnt, ar_cnt, rd_burst, rd_beat, last_idx;
  logic [15:0]  wr_addr, rd_addr;
  logic         rd_active;
  logic [127:0] rd_d;

  function automatic logic rnd_ready();
    if (mode == 1) return ($urandom_range(0, 99) < 30);
    return 1'b1;
  endfunction

  task automatic slave_zero();
    nasti.aw_ready = 1'b0; nasti.w_ready = 1'b0; nasti.ar_ready = 1'b0;
    nasti.b_valid = 1'b0; nasti.b_id = '0; nasti.b_resp = 2'b00; nasti.b_user = '0;
    nasti.r_valid = 1'b0; nasti.r_id = '0; nasti.r_data = '0; nasti.r_resp = 2'b00;
    nasti.r_last = 1'b0; nasti.r_user = '0;
    b_pend = 1'b0; b_burst = 0; aw_cnt = 0; ar_cnt = 0;
    rd_active = 1'b0; rd_burst = 0; rd_beat = 0; wr_addr = '0; rd_addr = '0;
  endtask

  initial begin
    slave_zero();
    forever begin
      @(negedge clk);
      if (rst) begin
        slave_zero();
      end else begin
        // B: response follows the last write beat
        nasti.b_valid = b_pend;
        nasti.b_resp  = (b_pend && mode == 3 && b_burst == 0) ? 2'b10 : 2'b00;
        if (nasti.b_valid && nasti.b_ready) b_pend = 1'b0;
        // R: stream stored data, with optional faults
        if (rd_active) begin
          rd_d = mem.exists(rd_addr) ? mem[rd_addr] : '0;
          if (mode == 2 && rd_burst == 1 && rd_beat == 2) rd_d[0] = ~rd_d[0];
          last_idx = (mode == 4 && rd_burst == 0) ? 1 : BL - 1;
          nasti.r_valid = 1'b1;
          nasti.r_data  = rd_d;
          nasti.r_last  = (rd_beat == last_idx);
          if (nasti.r_ready) begin
            rd_beat++;
            rd_addr = rd_addr + 16'd16;
            if (nasti.r_last) rd_active = 1'b0;
          end
        end else begin
          nasti.r_valid = 1'b0;
          nasti.r_last  = 1'b0;
          nasti.r_data  = '0;
        end
        // AW
        nasti.aw_ready = rnd_ready();
        if (nasti.aw_valid && nasti.aw_ready) begin
          wr_addr = nasti.aw_addr; b_burst = aw_cnt; aw_cnt++;
        end
        // W
        nasti.w_ready = rnd_ready();
        if (nasti.w_valid && nasti.w_ready) begin
          mem[wr_addr] = nasti.w_data;
          wr_addr = wr_addr + 16'd16;
          if (nasti.w_last) b_pend = 1'b1;
        end
        // AR
        nasti.ar_ready = rnd_ready();
        if (nasti.ar_valid && nasti.ar_ready) begin
          rd_addr = nasti.ar_addr; rd_beat = 0; rd_burst = ar_cnt; ar_cnt++;
          rd_active = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor (negedge + 1) ----------------
  logic         aw_stall, w_stall, ar_stall;
  logic [46:0]  aw_pl, ar_pl, aw_prev, ar_prev;
  logic [145:0] w_pl, w_prev;

  initial begin
    aw_stall = 1'b0; w_stall = 1'b0; ar_stall = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        aw_stall = 1'b0; w_stall = 1'b0; ar_stall = 1'b0;
      end else begin
        aw_pl = {nasti.aw_id, nasti.aw_lock, nasti.aw_cache, nasti.aw_prot, nasti.aw_qos,
                 nasti.aw_region, nasti.aw_user, nasti.aw_len, nasti.aw_size,
                 nasti.aw_burst, nasti.aw_addr};
        ar_pl = {nasti.ar_id, nasti.ar_lock, nasti.ar_cache, nasti.ar_prot, nasti.ar_qos,
                 nasti.ar_region, nasti.ar_user, nasti.ar_len, nasti.ar_size,
                 nasti.ar_burst, nasti.ar_addr};
        w_pl  = {nasti.w_user, nasti.w_strb, nasti.w_last, nasti.w_data};
        if (aw_stall) check("aw_hold", {nasti.aw_valid, aw_pl}, {1'b1, aw_prev});
        if (w_stall)  check("w_hold",  {nasti.w_valid, w_pl},   {1'b1, w_prev});
        if (ar_stall) check("ar_hold", {nasti.ar_valid, ar_pl}, {1'b1, ar_prev});
        aw_stall = nasti.aw_valid && !nasti.aw_ready; aw_prev = aw_pl;
        w_stall  = nasti.w_valid  && !nasti.w_ready;  w_prev  = w_pl;
        ar_stall = nasti.ar_valid && !nasti.ar_ready; ar_prev = ar_pl;
        if (nasti.aw_valid && nasti.aw_ready) begin
          if (exp_aw_q.size() == 0) begin
            n_checks++; $display("FAIL aw_unexpected: got %0h required none", aw_pl);
          end else check("aw", aw_pl, exp_aw_q.pop_front());
        end
        if (nasti.w_valid && nasti.w_ready) begin
          w_cnt++;
          if (exp_w_q.size() == 0) begin
            n_checks++; $display("FAIL w_unexpected: got %0h required none", w_pl);
          end else check("w", w_pl, exp_w_q.pop_front());
        end
        if (nasti.ar_valid && nasti.ar_ready) begin
          if (exp_ar_q.size() == 0) begin
            n_checks++; $display("FAIL ar_unexpected: got %0h required none", ar_pl);
          end else check("ar", ar_pl, exp_ar_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    flush_q();
  endtask

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic run_case(input int m, input logic with_rst, input string nm,
                          input logic [15:0] e_err, input logic e_pass,
                          input logic [15:0] e_fea);
    if (with_rst) do_reset();
    mode = m;
    push_expected();
    w_cnt = 0;
    pulse_start();
    check({nm, "_busy"}, busy, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      if (done) break;
      @(posedge clk); #2;
    end
    check({nm, "_done"}, done, 1'b1);
    check({nm, "_busy_low"}, busy, 1'b0);
    check({nm, "_pass"}, pass, e_pass);
    check({nm, "_err_count"}, err_count, e_err);
    check({nm, "_first_err_addr"}, first_err_addr, e_fea);
    check({nm, "_all_seen"}, exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0;
    do_reset();
    check("reset_status", {busy, done, pass, err_count, first_err_addr}, 0);
    check("reset_channels", {nasti.aw_valid, nasti.w_valid, nasti.ar_valid,
                             nasti.b_ready, nasti.r_ready, nasti.aw_addr,
                             nasti.ar_addr, nasti.w_strb, nasti.w_last}, 0);

    run_case(0, 1'b1, "clean",    16'd0, 1'b1, 16'h0000);
    run_case(1, 1'b1, "backpres", 16'd0, 1'b1, 16'h0000);
    run_case(2, 1'b1, "corrupt",  16'd1, 1'b0, 16'h1060);
    run_case(3, 1'b1, "b_resp",   16'd1, 1'b0, 16'h1000);
    run_case(4, 1'b1, "early",    16'd1, 1'b0, 16'h1010);

    // reset during write beat 2, then a clean run without another reset
    do_reset();
    mode = 0;
    push_expected();
    w_cnt = 0;
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      if (w_cnt >= 2) break;
      @(posedge clk); #2;
    end
    check("mid_reached_beat2", (w_cnt >= 2), 1'b1);
    check("mid_beat2_valid", nasti.w_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    check("mid_rst_outputs", {nasti.aw_valid, nasti.w_valid, nasti.ar_valid,
                              nasti.b_ready, nasti.r_ready, busy, done}, 0);
    flush_q();
    run_case(0, 1'b0, "after_rst", 16'd0, 1'b1, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nasti_memtest_master.md
# nasti_memtest_master

NASTI master that writes a deterministic address-derived pattern over a memory region in INCR bursts, then reads the region back and checks every beat, response and burst boundary. It is the initiating end of the NASTI channel and connects directly to a memory slave, behavioural or RTL, in simulation and FPGA bring-up. It reports busy/done/pass, an error count and the first failing address.

## Interface
Parameters:
- ID_WIDTH, 1: NASTI id width; master always drives id 0.
- ADDR_WIDTH, 16: NASTI address width.
- DATA_WIDTH, 128: data width; power of two, 32..256.
- USER_WIDTH, 1: user width; driven 0.
- BASE_ADDR, 0: byte address of the first burst; aligned to DATA_WIDTH/8.
- BURST_LEN, 4: beats per burst, 1..256.
- NUM_BURSTS, 2: bursts per pass, ≥1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  level-sampled; begins a test when the block is IDLE or DONE.
- busy  out  1  high from the cycle after start is accepted until DONE is entered.
- done  out  1  high in DONE; holds until the next accepted start or rst.
- pass  out  1  done && err_count==0.
- err_count  out  16  errors counted; saturates at 0xFFFF.
- first_err_addr  out  ADDR_WIDTH  byte address of the beat that raised the first error.
- nasti  modport nasti_channel.master  full AW/W/B/AR/R channels.

## Operation
- States: IDLE → AW → W → B → (next burst ? AW : AR) → R → (next burst ? AR : DONE).
- Only one transaction is outstanding at any time. The burst counter is cleared on entry to AR.
- Burst n address: BASE_ADDR + n·BURST_LEN·(DATA_WIDTH/8), truncated to ADDR_WIDTH.
- Address fields: len = BURST_LEN−1, size = log2(DATA_WIDTH/8), burst = INCR (2'b01). cache, prot, qos, region and lock are 0.
- Pattern: beat at byte address A carries, in 32-bit lane k, the value (A + 4k) mod 2^32, with A zero-extended.
- Write strobes: all ones. w_last = 1 only on beat BURST_LEN−1.
- Error conditions, each adding 1 to err_count:
  - b_resp ≠ 0.
  - b_id ≠ 0.
  - r_resp ≠ 0.
  - r_id ≠ 0.
  - r_data ≠ expected pattern.
  - r_last ≠ (beat == BURST_LEN−1).
- Several errors on the same beat count once.
- If r_last arrives early, R ends the burst there and the missing beats are not awaited. If r_last is missing on the final beat, R keeps accepting beats; each extra beat counts as an error until r_last is seen.
- first_err_addr is written only when err_count goes 0→1.
- On an accepted start: err_count and first_err_addr are cleared, done is cleared, and the FSM enters AW.
- start while busy is ignored.

## Timing
- All NASTI outputs and status outputs are registered. No valid depends combinationally on a ready.
- aw_valid/ar_valid:
  - Rise the cycle after entering AW/AR.
  - Held, with address stable, until the cycle where valid && ready.
  - Drop the following cycle.
- w_valid:
  - Rises the cycle after the AW handshake.
  - Data/last are held stable until the handshake, then advance to the next beat in the next cycle.
  - Back-to-back beats are allowed: one beat per cycle when w_ready stays high.
- b_ready is 1 throughout B. r_ready is 1 throughout R.
- The state advances the cycle after the final handshake of the phase.
- Minimum latency with always-ready slave and zero-delay responses: per write burst 1 (AW) + BURST_LEN (W) + 1 (B) cycles, plus one-cycle state transitions.
- Reset values: all valids 0, b_ready 0, r_ready 0, busy 0, done 0, pass 0, err_count 0, first_err_addr 0. All other NASTI fields are 0.
- rst asserted mid-transaction drops every valid/ready in the next cycle and returns to IDLE. The slave must be reset together with the master.

## Test plan
- Clean run (BASE_ADDR=0x1000, BURST_LEN=4, NUM_BURSTS=2, DATA_WIDTH=128), ideal slave → required:
  - AW at 0x1000 then 0x1040.
  - First W beat lanes: 0x1000, 0x1004, 0x1008, 0x100C.
  - done=1, pass=1, err_count=0.
- Backpressure: aw_ready/w_ready/ar_ready pseudo-random at ~30% duty → required:
  - No valid drops and no payload change before its handshake.
  - pass=1.
- Data corruption: slave flips bit 0 of read beat 2 of burst 1 → err_count=1, first_err_addr=0x1060, pass=0.
- Response error: b_resp=2'b10 on burst 0 → err_count≥1, first_err_addr=0x1000. The test still completes with done=1.
- Early r_last: r_last on beat 1 of burst 0 → err_count=1 and the FSM proceeds to burst 1 without hanging.
- Mid-burst reset: rst for 1 cycle during W beat 2, then start → all valids 0 the next cycle, then a full clean run with pass=1.
